// File: rtl/restoring_div_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
// The state encoding and the two's-complement helper are shared by the top and its bench.
package restoring_div_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Operands are zero-extended to MAX_W bits and truncated by the caller afterwards.
  // The low bits of a two's-complement negation depend only on the low bits of the input,
  // so one helper serves every legal WIDTH.
  function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration: shift {A,Q} left, trial-subtract M, restore or keep.
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_quo
);

  // A stays below M between steps, so WIDTH+1 bits always hold it. The shifted copy
  // gets one more guard bit so the trial difference's sign is unambiguous.
  logic [WIDTH+1:0] w_acc_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  assign w_acc_sh = {i_acc, i_quo[WIDTH-1]};
  assign w_diff   = w_acc_sh - {2'b00, i_div};
  assign w_neg    = w_diff[WIDTH+1];

  // NOTE: every output gets a default before the if, so no latch is inferred.
  always_comb begin
    o_acc = w_acc_sh[WIDTH:0];
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    if (!w_neg) begin
      o_acc    = w_diff[WIDTH:0];
      o_quo[0] = 1'b1;
    end
  end

endmodule

// File: rtl/restoring_divider_param.sv
// Multi-cycle WIDTH-bit restoring divider with signed mode, divide-by-zero detect,
// a busy flag and a one-cycle done pulse.
module restoring_divider_param
  import restoring_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_width_check
    $error("restoring_divider_param: WIDTH must be in 2..32");
  end

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dvd_neg;
  logic             r_dvs_neg;
  logic             r_dbz;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_zero;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_a_step;
  logic [WIDTH-1:0] w_q_step;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_zero    = (divisor == '0);
  assign w_dvd_neg = signed_mode & dividend[WIDTH-1];
  assign w_dvs_neg = signed_mode & divisor[WIDTH-1];
  assign w_dvd_mag = WIDTH'(neg_if(MAX_W'(dividend), w_dvd_neg));
  assign w_dvs_mag = WIDTH'(neg_if(MAX_W'(divisor), w_dvs_neg));

  restoring_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_acc(r_a),
    .i_quo(r_q),
    .i_div(r_m),
    .o_acc(w_a_step),
    .o_quo(w_q_step)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = w_zero ? DONE : ITER;
      ITER:    if (r_cnt == CNT_W'(1)) w_state_next = FIXUP;
      FIXUP:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a           <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_cnt         <= '0;
      r_dvd_neg     <= 1'b0;
      r_dvs_neg     <= 1'b0;
      r_dbz         <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a       <= '0;
            // A zero divisor skips the iterations; Q then carries the raw dividend to DONE.
            r_q       <= w_zero ? dividend : w_dvd_mag;
            r_m       <= w_dvs_mag;
            r_cnt     <= CNT_W'(WIDTH);
            r_dvd_neg <= w_dvd_neg;
            r_dvs_neg <= w_dvs_neg;
            r_dbz     <= w_zero;
            r_busy    <= 1'b1;
          end
        end
        ITER: begin
          r_a   <= w_a_step;
          r_q   <= w_q_step;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIXUP: begin
          // Truncating division: quotient sign is the XOR, remainder follows the dividend.
          if (r_dvd_neg ^ r_dvs_neg) r_q <= -r_q;
          if (r_dvd_neg)             r_a <= -r_a;
        end
        DONE: begin
          r_quotient    <= r_dbz ? '1 : r_q;
          r_remainder   <= r_dbz ? r_q : r_a[WIDTH-1:0];
          r_div_by_zero <= r_dbz;
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: doc/restoring_divider_param.md
Name: restoring_divider_param

Overview:
- Parametrised, multi-cycle restoring divider.
- Generalises the fixed 4-bit divider datapath/controlpath pair to WIDTH bits.
- Adds a signed mode, divide-by-zero detection, a busy flag and a one-cycle done pulse.
- Drop-in compute core for the top level; the seven-segment/LCD display path consumes quotient/remainder unchanged.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (legal 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- busy  output  1  high from the accept edge until done.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- div_by_zero  output  1  registered with results; high if divisor was 0.

Behaviour:
- Reset (async, any state): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; counter and internal A/Q/M cleared.
- A reset asserted mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, ITER, FIXUP, DONE.
- IDLE: on an edge with start=1:
  - Latch magnitudes: |dividend| and |divisor| when signed_mode, else raw values.
  - Latch the sign bits.
  - Set A=0 (WIDTH+1 bits), Q=dividend magnitude, count=WIDTH, busy=1.
  - If divisor==0: go to DONE directly. Otherwise go to ITER.
- ITER: one restoring step per cycle.
  - Shift {A,Q} left by 1.
  - Compute A-M. If negative, restore A and set Q[0]=0; else keep the difference and set Q[0]=1.
  - Decrement count. After the step with count==1, go to FIXUP.
- FIXUP: signed only.
  - Negate Q if the operand signs differ.
  - Negate the remainder if the dividend was negative (truncation toward zero; remainder takes the dividend's sign).
  - Unsigned: pass through. Always go to DONE.
- DONE:
  - Register quotient/remainder/div_by_zero.
  - done=1 for exactly this cycle; busy=0 from the same edge.
  - Go to IDLE.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+WIDTH+2. Divide-by-zero: done after edge E0+1.
- Divide by zero: quotient = all ones, remainder = dividend (raw input bits), div_by_zero=1.
- Signed overflow (most-negative / -1): quotient = most-negative value (wraps), remainder=0, div_by_zero=0. No extra flag.
- start while busy: ignored; no queueing, operands are not re-sampled.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE (back-to-back spacing WIDTH+3 cycles).
- Outputs hold their last values until the next DONE. div_by_zero is cleared/updated only at DONE.
- Width rules:
  - A is WIDTH+1 bits so the subtract sign is bit WIDTH.
  - Magnitude of the most-negative value is represented as unsigned WIDTH bits without loss.

Decomposition:
- Package restoring_div_pkg:
  - State enum (IDLE, ITER, FIXUP, DONE).
  - Helper function for two's-complement absolute value/negate, parametrised by width.
- One natural sub-module: restoring_div_step.
  - Combinational single iteration.
  - Inputs {A,Q}, M. Outputs next {A,Q}.
  - Instantiated once inside the iterative datapath.

Test Plan:
- WIDTH=8, unsigned 200/7, start at E0 -> done in the cycle after E10; quotient=28 (0x1C), remainder=4, div_by_zero=0, busy high E0..E10.
- WIDTH=8, signed -100/7 (0x9C/0x07) -> quotient=0xF2 (-14), remainder=0xFE (-2); signed 100/-7 -> quotient=0xF2, remainder=0x02.
- WIDTH=8, 0x55/0 -> done after E1, quotient=0xFF, remainder=0x55, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- WIDTH=8, signed -128/-1 -> quotient=0x80, remainder=0, div_by_zero=0; unsigned 7/9 -> quotient=0, remainder=7.
- start pulsed again at E3 during 200/7 with different operands -> ignored; the single done still gives 28 r 4.
- rst asserted asynchronously mid-ITER (between edges) -> all outputs 0 immediately, no done; a new 15/4 afterwards -> quotient=3, remainder=3.
- Parameter sweep WIDTH=4, 16: random operands in both modes vs a reference model; done latency is exactly WIDTH+2 edges.
